fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-003 Parameter BURST, default 4, maximum accepted words per grant tenure (1..255).
REQ-004 wr_clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NREQ  per-requester write request; bit i held high while requester i has a valid word.
REQ-007 req_data  input  NREQ*WIDTH  requester i word on bits [i*WIDTH +: WIDTH].
REQ-008 fifo_full  input  1  full flag from downstream FIFO write side.
REQ-009 gnt  output  NREQ  registered one-hot (or zero) grant.
REQ-010 write_en  output  1  FIFO write strobe.
REQ-011 data_out  output  WIDTH  word presented to FIFO data input.
REQ-012 busy  output  1  high while state is OWN.

Function
REQ-013 FSM states SHALL be IDLE (gnt=0) and OWN (gnt one-hot on owner).
REQ-014 accept SHALL be gnt[i] & req[i] & ~fifo_full for owner i; write_en SHALL equal accept combinationally, no registered delay.
REQ-015 data_out SHALL be req_data lane of owner while in OWN, zero in IDLE.
REQ-016 requester i SHALL treat accept in a cycle as consumption of its current word and may present the next word the following cycle.
REQ-017 IDLE->OWN: when |req, gnt SHALL assert on the round-robin winner exactly 1 cycle later.
REQ-018 Round-robin winner SHALL be the first set req bit searching upward from ptr, wrapping NREQ-1 -> 0; ptr SHALL update to winner+1 mod NREQ at each grant.
REQ-019 beat_cnt SHALL clear on each new grant and increment only on accept; cycles with fifo_full=1 SHALL not count and SHALL not release the grant.
REQ-020 Tenure SHALL end on the edge where req[owner]=0, or where an accept brings beat_cnt to BURST.
REQ-021 At tenure end, if any req bit (evaluated excluding owner if owner's burst expired and another req is set) is high, the next owner SHALL be granted on the very next cycle with no IDLE bubble; otherwise state SHALL go IDLE.
REQ-022 A requester whose burst expired SHALL be re-granted immediately only when no other req bit is set.
REQ-023 gnt SHALL never have more than one bit set; write_en SHALL never assert while fifo_full=1.
REQ-024 req deassertion by a non-owner SHALL have no effect on current tenure.

Reset
REQ-025 With rst_n=0 at a rising edge: state=IDLE, gnt=0, ptr=0, beat_cnt=0, busy=0; write_en and data_out consequently 0.
REQ-026 Reset mid-tenure SHALL drop the grant on that edge with no further write_en; the in-flight word is not written.
REQ-027 First grant after reset SHALL favour requester 0 among simultaneous requests.

Configuration
REQ-028 Macro FIFO_ARB_WCNT_EN: when defined, output wr_count (16 bits) SHALL count total accepts, saturating at 16'hFFFF, cleared by reset.
REQ-029 When FIFO_ARB_WCNT_EN is undefined, wr_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset, then req=4'b0001 held, fifo_full=0 -> gnt=0001 at cycle 1, write_en high cycles 1-4, release after 4th accept, re-grant 0001 next cycle (sole requester).
REQ-031 req=4'b1111 held -> grant order 0,1,2,3,0, each tenure exactly 4 write_en pulses, no idle cycle between tenures.
REQ-032 Owner 2 granted, fifo_full=1 for 5 cycles mid-burst -> write_en=0 during stall, gnt stays 0100, total 4 accepts still delivered.
REQ-033 Owner 1 drops req after 2 accepts while req[3]=1 -> gnt=1000 next cycle, data_out follows lane 3.
REQ-034 rst_n=0 during tenure after 1 accept -> gnt=0, write_en=0 that edge; after release with req=1010 -> gnt=0010 first.
REQ-035 With FIFO_ARB_WCNT_EN defined, 70000 accepts -> wr_count=16'hFFFF and holds.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NREQ requesters share one FIFO write port with bounded bursts.
// Optional macro FIFO_ARB_WCNT_EN adds a saturating 16-bit total-accept counter (o_wr_count).
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                  i_wr_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  input  logic                  i_fifo_full,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_write_en,
  output logic [WIDTH-1:0]      o_data_out,
`ifdef FIFO_ARB_WCNT_EN
  output logic [15:0]           o_wr_count,
`endif
  output logic                  o_busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] BurstLast = 8'(BURST - 1);
  localparam logic [PW-1:0] LastIdx = PW'(NREQ - 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_beat;
  logic            r_busy;

  logic            w_owner_req;
  logic            w_accept;
  logic            w_last_beat;
  logic            w_tenure_end;
  logic [NREQ-1:0] w_owner_mask;
  logic [NREQ-1:0] w_others;
  logic [NREQ-1:0] w_cand;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_win_next;

  assign w_owner_req  = i_req[r_owner];
  // Gated by reset so the in-flight word is never written on a reset edge.
  assign w_accept     = (r_state == StOwn) & w_owner_req & ~i_fifo_full & i_rst_n;
  assign w_last_beat  = w_accept & (r_beat == BurstLast);
  assign w_tenure_end = ~w_owner_req | w_last_beat;
  assign w_owner_mask = NREQ'(1) << r_owner;
  assign w_others     = i_req & ~w_owner_mask;

  // An expired owner competes only when nobody else is asking.
  always_comb begin
    w_cand = i_req;
    if ((r_state == StOwn) && w_last_beat && (|w_others)) begin
      w_cand = w_others;
    end
  end

  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  assign w_win_next = (w_win == LastIdx) ? '0 : w_win + 1'b1;

  always_ff @(posedge i_wr_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StOwn;
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_ptr   <= w_win_next;
            r_beat  <= '0;
            r_busy  <= 1'b1;
          end
        end
        StOwn: begin
          if (w_tenure_end) begin
            if (w_found) begin
              r_gnt   <= NREQ'(1) << w_win;
              r_owner <= w_win;
              r_ptr   <= w_win_next;
              r_beat  <= '0;
            end else begin
              r_state <= StIdle;
              r_gnt   <= '0;
              r_beat  <= '0;
              r_busy  <= 1'b0;
            end
          end else if (w_accept) begin
            r_beat <= r_beat + 8'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_busy     = r_busy;
  assign o_write_en = w_accept;
  assign o_data_out = r_busy ? i_req_data[r_owner*WIDTH +: WIDTH] : '0;

`ifdef FIFO_ARB_WCNT_EN
  logic [15:0] r_wr_count;

  always_ff @(posedge i_wr_clk) begin
    if (!i_rst_n) begin
      r_wr_count <= '0;
    end else if (w_accept && (r_wr_count != 16'hFFFF)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign o_wr_count = r_wr_count;
`endif

endmodule
